// File: rtl/asic_irq_collect4.sv
// 4-channel interrupt collector: sticky level/edge pending bits, enable mask, post-service hold-off.
// Latency: src -> pending 1 edge (3 edges with OH_IRQ_SYNC_EN); pending/mask -> req combinational.
// Backpressure: none; events arriving while a bit is already pending are absorbed, req is held low during hold-off.
module asic_irq_collect4 #(
  parameter     PROP    = "DEFAULT",
  parameter int HOLDOFF = 4,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] src,
  input  logic [3:0] edge_sel,
  input  logic [3:0] mask,
  input  logic [3:0] clr,
  output logic [3:0] pending,
  output logic [3:0] req,
  output logic       hold
);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_ASSERTED = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    s, s_q, rise, set, mp;

  // PROP is a pass-through tag for implementation tooling; it selects no logic.
  if (PROP == "DEFAULT") begin : g_prop_default
  end

`ifdef OH_IRQ_SYNC_EN
  logic [3:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src;
`endif

  // s_q resets to 0 so a source already high at reset release is seen as a rising edge.
  assign rise = s & ~s_q;
  assign set  = (edge_sel & rise) | (~edge_sel & s);
  assign mp   = pending & mask;
  assign hold = (state == ST_HOLD);
  assign req  = hold ? 4'b0000 : mp;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s_q     <= '0;
      pending <= '0;
      state   <= ST_ARMED;
      cnt     <= '0;
    end else begin
      s_q     <= s;
      pending <= set | (pending & ~clr);
      state   <= state_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ARMED: begin
        if (|mp) state_nxt = ST_ASSERTED;
      end
      ST_ASSERTED: begin
        if (mp == 4'b0000) begin
          if (HOLDOFF > 0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CW'(HOLDOFF - 1);
          end else begin
            state_nxt = ST_ARMED;
          end
        end
      end
      ST_HOLD: begin
        // Entered with HOLDOFF-1 so the window spans exactly HOLDOFF cycles.
        if (cnt == '0) state_nxt = ST_ARMED;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ST_ARMED;
    endcase
  end

endmodule

// File: tb/tb_asic_irq_collect4.sv
// Directed bench for asic_irq_collect4 (HOLDOFF=4, no synchronizer): reset, edge capture,
// set/clear priority, mask gating and hold-off behaviour.
module tb_asic_irq_collect4;

  logic       clk;
  logic       nreset;
  logic [3:0] src, edge_sel, mask, clr;
  logic [3:0] pending, req;
  logic       hold;

  int checks = 0;
  int fails  = 0;

  asic_irq_collect4 #(.PROP("DEFAULT"), .HOLDOFF(4), .CW(8)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .src      (src),
    .edge_sel (edge_sel),
    .mask     (mask),
    .clr      (clr),
    .pending  (pending),
    .req      (req),
    .hold     (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    nreset   = 1'b0;
    src      = 4'hF;
    edge_sel = 4'h0;
    mask     = 4'hF;
    clr      = 4'h0;

    // Reset with all sources high
    step();
    step();
    chk("rst_pending", pending, 4'h0);
    chk("rst_req",     req,     4'h0);
    chk("rst_hold",    {3'b0, hold}, 4'h0);

    // Release: level capture on the first edge
    nreset = 1'b1;
    step();
    chk("rel_pending", pending, 4'hF);
    chk("rel_req",     req,     4'hF);
    chk("rel_hold",    {3'b0, hold}, 4'h0);

    // Clear everything and let the hold-off window run out
    src = 4'h0; edge_sel = 4'h1; mask = 4'h1; clr = 4'hF;
    step();
    chk("clrall_pending", pending, 4'h0);
    clr = 4'h0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_hold", {3'b0, hold}, 4'h0);
    chk("idle_req",  req,          4'h0);

    // Edge capture: 1-cycle pulse on src[0]
    src = 4'h1;
    step();
    chk("edge_pending", pending, 4'h1);
    chk("edge_req",     req,     4'h1);
    src = 4'h0;
    step();
    chk("edge_sticky_pending", pending, 4'h1);
    chk("edge_sticky_req",     req,     4'h1);
    clr = 4'h1;
    step();
    chk("edge_clr_pending", pending, 4'h0);
    chk("edge_clr_hold",    {3'b0, hold}, 4'h0);
    clr = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("holdoff_on", {3'b0, hold}, 4'h1);
    end
    step();
    chk("holdoff_off", {3'b0, hold}, 4'h0);

    // Coincident rise and clear on channel 1: set wins
    edge_sel = 4'h3; mask = 4'h0;
    src = 4'h2; clr = 4'h2;
    step();
    chk("coinc_pending", pending, 4'h2);
    src = 4'h0;
    step();
    chk("coinc_clr_pending", pending, 4'h0);
    clr = 4'h0;

    // Mask gating on channel 2 (level mode)
    edge_sel = 4'h0; src = 4'h4;
    step();
    src = 4'h0;
    chk("mask_pending", pending, 4'h4);
    chk("mask_req",     req,     4'h0);
    step();
    chk("mask_keep_pending", pending, 4'h4);
    chk("mask_keep_req",     req,     4'h0);
    chk("mask_keep_hold",    {3'b0, hold}, 4'h0);
    mask = 4'h4;
    #1;
    chk("unmask_req_same_cycle", req, 4'h4);
    step();
    clr = 4'h4;
    step();
    chk("unmask_clr_pending", pending, 4'h0);
    clr = 4'h0;
    step();
    chk("asserted_to_hold", {3'b0, hold}, 4'h1);

    // Rise on channel 3 during hold-off: captured, req held until hold falls
    edge_sel = 4'h8; mask = 4'h8; src = 4'h8;
    step();
    src = 4'h0;
    chk("hold_capture_pending", pending, 4'h8);
    chk("hold_capture_req",     req,     4'h0);
    chk("hold_capture_hold",    {3'b0, hold}, 4'h1);
    step();
    chk("hold_mid_req",  req,          4'h0);
    chk("hold_mid_hold", {3'b0, hold}, 4'h1);
    step();
    chk("hold_last_req",  req,          4'h0);
    chk("hold_last_hold", {3'b0, hold}, 4'h1);
    step();
    chk("hold_exit_hold", {3'b0, hold}, 4'h0);
    chk("hold_exit_req",  req,          4'h8);
    step();
    chk("post_exit_req",  req,          4'h8);

    // Repeated edge while already pending is absorbed; mask never clears pending
    src = 4'h8;
    step();
    src = 4'h0;
    mask = 4'h0;
    #1;
    chk("absorb_pending", pending, 4'h8);
    chk("masked_req",     req,     4'h0);

    // Mid-operation reset discards state
    nreset = 1'b0;
    step();
    chk("midrst_pending", pending, 4'h0);
    chk("midrst_hold",    {3'b0, hold}, 4'h0);
    nreset = 1'b1;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
